// File: rtl/axi4_lite_pkg.sv
// Shared encodings for the AXI4-Lite arbiter: FSM state codes and response codes.
package axi4_lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_D  = 3'd2,
    ST_WR_AW = 3'd3,
    ST_WR_B  = 3'd4
  } arb_state_t;

  // Same values as the shared AXI4-Lite interface header.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_lite_arbiter_2to1_rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie, the side not picked last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);

  always_comb begin
    any = |req;
    win = (req == 2'b11) ? ~last : req[1];
  end

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter; one transaction in flight, round-robin
// at transaction granularity, request/response channels muxed on the registered grant.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no grant; arbitrate between requesting masters
// ST_RD_A  | forward AR of the granted master
// ST_RD_D  | forward R back to the granted master
// ST_WR_AW | forward AW and W independently until both done
// ST_WR_B  | forward B back to the granted master
module axi4_lite_arbiter_2to1
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                m0_awvalid,
  output logic                m0_awready,
  input  logic [ADDR_W-1:0]   m0_awaddr,
  input  logic                m0_wvalid,
  output logic                m0_wready,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_bvalid,
  input  logic                m0_bready,
  output logic [1:0]          m0_bresp,
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,

  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,

  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,

  output logic                busy,
  output logic                gnt
);

  arb_state_t state;
  logic       gnt_q;
  logic       last_gnt;
  logic       busy_q;
  logic       aw_done;
  logic       w_done;

  logic [1:0] req;
  logic       win;
  logic       any;

  assign req = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};

  rr_pick2 u_pick (
    .req  (req),
    .last (last_gnt),
    .win  (win),
    .any  (any)
  );

  logic in_ra, in_rd, in_wa, in_wb;
  assign in_ra = (state == ST_RD_A);
  assign in_rd = (state == ST_RD_D);
  assign in_wa = (state == ST_WR_AW);
  assign in_wb = (state == ST_WR_B);

  logic                sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic [ADDR_W-1:0]   sel_awaddr, sel_araddr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;

  assign sel_awvalid = gnt_q ? m1_awvalid : m0_awvalid;
  assign sel_awaddr  = gnt_q ? m1_awaddr  : m0_awaddr;
  assign sel_wvalid  = gnt_q ? m1_wvalid  : m0_wvalid;
  assign sel_wdata   = gnt_q ? m1_wdata   : m0_wdata;
  assign sel_wstrb   = gnt_q ? m1_wstrb   : m0_wstrb;
  assign sel_bready  = gnt_q ? m1_bready  : m0_bready;
  assign sel_arvalid = gnt_q ? m1_arvalid : m0_arvalid;
  assign sel_araddr  = gnt_q ? m1_araddr  : m0_araddr;
  assign sel_rready  = gnt_q ? m1_rready  : m0_rready;

  // Once a write channel has handshaked its valid is masked until B completes.
  assign s_awvalid = in_wa & sel_awvalid & ~aw_done;
  assign s_awaddr  = in_wa ? sel_awaddr : '0;
  assign s_wvalid  = in_wa & sel_wvalid & ~w_done;
  assign s_wdata   = in_wa ? sel_wdata : '0;
  assign s_wstrb   = in_wa ? sel_wstrb : '0;
  assign s_bready  = in_wb & sel_bready;
  assign s_arvalid = in_ra & sel_arvalid;
  assign s_araddr  = in_ra ? sel_araddr : '0;
  assign s_rready  = in_rd & sel_rready;

  logic g0, g1;
  assign g0 = ~gnt_q;
  assign g1 = gnt_q;

  assign m0_awready = in_wa & g0 & s_awready & ~aw_done;
  assign m0_wready  = in_wa & g0 & s_wready & ~w_done;
  assign m0_bvalid  = in_wb & g0 & s_bvalid;
  assign m0_bresp   = (in_wb & g0) ? s_bresp : 2'b00;
  assign m0_arready = in_ra & g0 & s_arready;
  assign m0_rvalid  = in_rd & g0 & s_rvalid;
  assign m0_rdata   = (in_rd & g0) ? s_rdata : '0;
  assign m0_rresp   = (in_rd & g0) ? s_rresp : 2'b00;

  assign m1_awready = in_wa & g1 & s_awready & ~aw_done;
  assign m1_wready  = in_wa & g1 & s_wready & ~w_done;
  assign m1_bvalid  = in_wb & g1 & s_bvalid;
  assign m1_bresp   = (in_wb & g1) ? s_bresp : 2'b00;
  assign m1_arready = in_ra & g1 & s_arready;
  assign m1_rvalid  = in_rd & g1 & s_rvalid;
  assign m1_rdata   = (in_rd & g1) ? s_rdata : '0;
  assign m1_rresp   = (in_rd & g1) ? s_rresp : 2'b00;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire;
  assign aw_fire = s_awvalid & s_awready;
  assign w_fire  = s_wvalid & s_wready;
  assign b_fire  = s_bvalid & s_bready;
  assign ar_fire = s_arvalid & s_arready;
  assign r_fire  = s_rvalid & s_rready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      gnt_q    <= 1'b0;
      last_gnt <= 1'b1;
      busy_q   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            gnt_q  <= win;
            busy_q <= 1'b1;
            // Writes go first within a master to keep MMIO store ordering.
            state  <= (win ? m1_awvalid : m0_awvalid) ? ST_WR_AW : ST_RD_A;
          end
        end
        ST_RD_A: begin
          if (ar_fire) state <= ST_RD_D;
        end
        ST_RD_D: begin
          if (r_fire) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            last_gnt <= gnt_q;
          end
        end
        ST_WR_AW: begin
          aw_done <= aw_done | aw_fire;
          w_done  <= w_done | w_fire;
          if ((aw_done | aw_fire) && (w_done | w_fire)) state <= ST_WR_B;
        end
        ST_WR_B: begin
          if (b_fire) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            last_gnt <= gnt_q;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign gnt  = gnt_q;

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench for the 2:1 AXI4-Lite arbiter: masters and a zero-wait slave model,
// responses checked against a scoreboard queue filled when each request is issued.
`timescale 1ns/1ps
module tb_axi4_lite_arbiter_2to1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr [2];
  logic [31:0] m_wdata  [2];
  logic [3:0]  m_wstrb  [2];
  logic [1:0]  m_bresp  [2];
  logic [31:0] m_araddr [2];
  logic [31:0] m_rdata  [2];
  logic [1:0]  m_rresp  [2];

  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        busy, gnt;

  axi4_lite_arbiter_2to1 dut (
    .clk(clk), .rst(rst),
    .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]), .m0_awaddr(m_awaddr[0]),
    .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]), .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]),
    .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]), .m0_bresp(m_bresp[0]),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]), .m0_araddr(m_araddr[0]),
    .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]),
    .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]), .m1_awaddr(m_awaddr[1]),
    .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]), .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]),
    .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]), .m1_bresp(m_bresp[1]),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]), .m1_araddr(m_araddr[1]),
    .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .busy(busy), .gnt(gnt)
  );

  typedef struct {
    bit          is_wr;
    int unsigned mst;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } srd_t;

  exp_t       exp_q[$];
  srd_t       srd_q[$];
  logic [1:0] sb_resp_q[$];

  int tests = 0;
  int fails = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_pop(input bit is_wr, input int unsigned m, input logic [31:0] d,
                           input logic [1:0] r);
    exp_t e;
    tests++;
    assert (exp_q.size() != 0) else begin
      fails++;
      $error("FAIL sb_underflow: observed response on m%0d with empty scoreboard", m);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_kind", 32'(is_wr), 32'(e.is_wr));
      chk("sb_master", m, e.mst);
      if (!is_wr) chk("sb_rdata", d, e.data);
      chk("sb_resp", 32'(r), 32'(e.resp));
    end
  endtask

  // Phases per cycle (negedge = T): T+0 master valids drop after handshake,
  // T+2 main stimulus, T+6 slave drives, T+8 handshakes sampled, T+10 posedge.
  logic [1:0] ar_hs, aw_hs, w_hs;
  initial begin : env
    bit   r_pend, r_done, aw_got, w_got, b_done;
    srd_t cur;
    r_pend = 0; r_done = 0; aw_got = 0; w_got = 0; b_done = 0;
    cur = '{data: 32'h0, resp: 2'b00};
    ar_hs = '0; aw_hs = '0; w_hs = '0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    forever begin
      @(negedge clk);
      m_arvalid = m_arvalid & ~ar_hs;
      m_awvalid = m_awvalid & ~aw_hs;
      m_wvalid  = m_wvalid & ~w_hs;
      ar_hs = '0; aw_hs = '0; w_hs = '0;
      #6;
      if (rst) begin
        r_pend = 0; r_done = 0; aw_got = 0; w_got = 0; b_done = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
      end else begin
        if (r_done) begin s_rvalid = 0; r_done = 0; end
        if (r_pend) begin
          s_rvalid = 1; s_rdata = cur.data; s_rresp = cur.resp; r_pend = 0;
        end
        if (b_done) begin s_bvalid = 0; b_done = 0; end
        if (aw_got && w_got) begin
          s_bvalid = 1;
          s_bresp = (sb_resp_q.size() != 0) ? sb_resp_q.pop_front() : 2'b00;
          aw_got = 0; w_got = 0;
        end
        s_arready = s_arvalid;
        s_awready = s_awvalid;
        s_wready  = s_wvalid;
      end
      #2;
      ar_hs = m_arvalid & m_arready;
      aw_hs = m_awvalid & m_awready;
      w_hs  = m_wvalid & m_wready;
      if (s_arvalid && s_arready) begin
        ar_cnt++;
        if (srd_q.size() != 0) cur = srd_q.pop_front();
        r_pend = 1;
      end
      if (s_rvalid && s_rready) r_done = 1;
      if (s_awvalid && s_awready) begin aw_cnt++; aw_got = 1; end
      if (s_wvalid && s_wready) begin w_cnt++; w_got = 1; end
      if (s_bvalid && s_bready) b_done = 1;
      for (int m = 0; m < 2; m++) begin
        if (m_rvalid[m] && m_rready[m]) check_pop(1'b0, m, m_rdata[m], m_rresp[m]);
        if (m_bvalid[m] && m_bready[m]) check_pop(1'b1, m, 32'h0, m_bresp[m]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic rd(input int m, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    srd_q.push_back('{data: d, resp: r});
    exp_q.push_back('{is_wr: 1'b0, mst: m, data: d, resp: r});
    m_araddr[m] = a;
    m_arvalid[m] = 1'b1;
  endtask

  task automatic wr(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] r, input bit w_now);
    sb_resp_q.push_back(r);
    exp_q.push_back('{is_wr: 1'b1, mst: m, data: 32'h0, resp: r});
    m_awaddr[m] = a;
    m_wdata[m] = d;
    m_wstrb[m] = s;
    m_awvalid[m] = 1'b1;
    if (w_now) m_wvalid[m] = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && !busy) return;
      step();
    end
    tests++;
    fails++;
    $error("FAIL %s: timeout, busy=%0b pending=%0d", tag, busy, exp_q.size());
  endtask

  initial begin : main
    int n;
    int aw0, w0;
    bit b_seen;
    m_awvalid = '0; m_wvalid = '0; m_arvalid = '0;
    m_bready = 2'b11; m_rready = 2'b11;
    for (int m = 0; m < 2; m++) begin
      m_awaddr[m] = '0; m_wdata[m] = '0; m_wstrb[m] = '0; m_araddr[m] = '0;
    end
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
    chk("rst_m_outs", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 0);
    chk("rst_m0_rdata", m_rdata[0], 0);
    chk("rst_s_araddr", s_araddr, 0);

    // Tie right after reset: m0 first, m1 waits and follows.
    rd(0, 32'h2000_0000, 32'h11, 2'b00);
    rd(1, 32'h3000_0000, 32'h22, 2'b00);
    step();
    chk("tie1_gnt", gnt, 0);
    chk("tie1_s_araddr", s_araddr, 32'h2000_0000);
    wait_idle("tie1", 30);

    // m1 was granted last, so m0 wins the next tie.
    rd(0, 32'h2000_0010, 32'h33, 2'b00);
    rd(1, 32'h3000_0010, 32'h44, 2'b00);
    step();
    chk("tie2_gnt", gnt, 0);
    wait_idle("tie2", 30);

    // m0 alone: latency and occupancy.
    rd(0, 32'h1000_0004, 32'hA5, 2'b00);
    settle();
    chk("lat_s_arvalid_t0", s_arvalid, 0);
    step();
    chk("lat_s_arvalid_t1", s_arvalid, 1);
    chk("lat_s_araddr", s_araddr, 32'h1000_0004);
    chk("lat_busy", busy, 1);
    n = 1;
    while (busy && n < 20) begin
      step();
      n++;
      chk("m1_no_rvalid", m_rvalid[1], 0);
    end
    chk("rd_occupancy", n, 3);
    wait_idle("rd_m0", 10);

    // m0 was granted last, so m1 wins this tie.
    rd(1, 32'h3000_0020, 32'h55, 2'b00);
    rd(0, 32'h2000_0020, 32'h66, 2'b00);
    step();
    chk("tie3_gnt", gnt, 1);
    wait_idle("tie3", 30);

    // m1 write with W two cycles behind AW.
    aw0 = aw_cnt; w0 = w_cnt;
    wr(1, 32'h4000_0000, 32'h41, 4'h1, 2'b00, 1'b0);
    step();
    chk("wlate_gnt", gnt, 1);
    chk("wlate_s_awvalid", s_awvalid, 1);
    chk("wlate_s_wvalid_early", s_wvalid, 0);
    step();
    chk("wlate_aw_masked", s_awvalid, 0);
    m_wvalid[1] = 1'b1;
    settle();
    chk("wlate_s_wvalid", s_wvalid, 1);
    chk("wlate_s_wdata", s_wdata, 32'h41);
    chk("wlate_s_wstrb", s_wstrb, 4'h1);
    wait_idle("wlate", 20);
    chk("wlate_aw_count", aw_cnt - aw0, 1);
    chk("wlate_w_count", w_cnt - w0, 1);

    // m0 write and read together: the write finishes before any AR reaches the slave.
    wr(0, 32'h5000_0000, 32'hCAFE, 4'hF, 2'b10, 1'b1);
    rd(0, 32'h5000_0004, 32'hBEEF, 2'b00);
    step();
    chk("order_s_awvalid", s_awvalid, 1);
    chk("order_s_wvalid", s_wvalid, 1);
    chk("order_s_arvalid", s_arvalid, 0);
    n = 1;
    while (busy && n < 20) begin
      step();
      n++;
    end
    chk("wr_occupancy", n, 3);
    for (int i = 0; i < 20 && (exp_q.size() != 0 || busy); i++) begin
      b_seen = (exp_q.size() < 2);
      if (s_arvalid) chk("order_b_before_ar", b_seen, 1);
      step();
    end
    wait_idle("order", 5);

    // DECERR read with m1 holding rready low for 3 cycles.
    m_rready[1] = 1'b0;
    rd(1, 32'hDEAD_0000, 32'hDEAD, 2'b11);
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("decerr_rvalid_held", m_rvalid[1], 1);
      chk("decerr_rresp_held", m_rresp[1], 2'b11);
    end
    m_rready[1] = 1'b1;
    wait_idle("decerr", 10);
    chk("decerr_idle", busy, 0);

    // Reset while in RD_D abandons the read.
    m_rready[0] = 1'b0;
    srd_q.push_back('{data: 32'h99, resp: 2'b00});
    m_araddr[0] = 32'h6000_0000;
    m_arvalid[0] = 1'b1;
    step();
    step();
    step();
    chk("rstmid_in_rd_d", m_rvalid[0], 1);
    rst = 1'b1;
    step();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m_rvalid, m_bvalid}, 0);
    rst = 1'b0;
    m_rready[0] = 1'b1;
    step();
    rd(1, 32'h7000_0000, 32'h77, 2'b00);
    step();
    chk("post_rst_gnt", gnt, 1);
    wait_idle("post_rst", 20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
